// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Fetches over a variable-latency req/ack memory port; decode may freeze or redirect it.
module if_stage_fetch #(
  parameter int                  WORD_LEN = 16,
  parameter logic [WORD_LEN-1:0] PC_RESET = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard_detected_in,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_addr,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] pc_out,
  output logic                if_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [WORD_LEN-1:0] ONE = {{(WORD_LEN-1){1'b0}}, 1'b1};
  localparam logic [WORD_LEN-1:0] NOP = '0;

  logic [1:0]          state_q, state_d;
  logic [WORD_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic                stale_q, stale_d;
  logic [WORD_LEN-1:0] skid_instr_q, skid_instr_d;
  logic [WORD_LEN-1:0] skid_pc_q, skid_pc_d;
  logic [WORD_LEN-1:0] instr_q, instr_d;
  logic [WORD_LEN-1:0] pcout_q, pcout_d;
  logic                valid_q, valid_d;

  logic                ack_v;
  logic [WORD_LEN-1:0] pc_inc;

  assign ack_v  = imem_ack && (state_q == REQ);
  assign pc_inc = pc_q + ONE;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_d      = stale_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pcout_d      = pcout_q;
    valid_d      = valid_q;

    if (br_taken) begin
      // A redirect flushes IF/ID even under a freeze; an in-flight fetch is marked stale.
      pc_d    = br_addr;
      instr_d = NOP;
      valid_d = 1'b0;
      state_d = REQ;
      if (state_q == REQ) begin
        stale_d = ack_v ? 1'b0 : 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
          if (!hazard_detected_in) begin
            instr_d = NOP;
            valid_d = 1'b0;
          end
        end
        REQ: begin
          if (ack_v && !stale_q) begin
            pc_d = pc_inc;
            if (!hazard_detected_in) begin
              instr_d = imem_rdata;
              pcout_d = pc_inc;
              valid_d = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_inc;
              state_d      = HOLD;
            end
          end else begin
            if (ack_v) begin
              stale_d = 1'b0;
            end
            if (!hazard_detected_in) begin
              instr_d = NOP;
              valid_d = 1'b0;
            end
          end
        end
        HOLD: begin
          if (!hazard_detected_in) begin
            instr_d = skid_instr_q;
            pcout_d = skid_pc_q;
            valid_d = 1'b1;
            state_d = REQ;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // The request address is frozen until the pending fetch is acknowledged.
  always_comb begin
    addr_d = pc_d;
    if ((state_q == REQ) && !imem_ack) begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= PC_RESET;
      addr_q       <= PC_RESET;
      stale_q      <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= NOP;
      pcout_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      stale_q      <= stale_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pcout_q      <= pcout_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = addr_q;
  assign instruction = instr_q;
  assign pc_out      = pcout_q;
  assign if_valid    = valid_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed-vector bench for if_stage_fetch: per-cycle table of inputs and expected
// IF/ID and fetch-port values, plus async-reset and PC wrap-around sequences.
module tb_if_stage_fetch;

  typedef struct {
    string       name;
    logic        hz;
    logic        br;
    logic [15:0] ba;
    logic        ack;
    logic [15:0] rd;
    logic [15:0] eInstr;
    logic [15:0] ePc;
    logic        eValid;
    logic        eReq;
    logic [15:0] eAddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        brTaken;
  logic [15:0] brAddr;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemRdata;
  logic [15:0] instr;
  logic [15:0] pcOut;
  logic        ifValid;

  logic        rst2;
  logic        hazard2 = 1'b0;
  logic        brTaken2 = 1'b0;
  logic [15:0] brAddr2 = 16'h0000;
  logic        imemReq2;
  logic [15:0] imemAddr2;
  logic        imemAck2;
  logic [15:0] imemRdata2;
  logic [15:0] instr2;
  logic [15:0] pcOut2;
  logic        ifValid2;

  int nVec = 0;
  int nMis = 0;
  vec_t vecs[$];

  if_stage_fetch #(.WORD_LEN(16), .PC_RESET(16'h0000)) dut (
    .clk(clk), .rst(rst), .hazard_detected_in(hazard), .br_taken(brTaken),
    .br_addr(brAddr), .imem_req(imemReq), .imem_addr(imemAddr), .imem_ack(imemAck),
    .imem_rdata(imemRdata), .instruction(instr), .pc_out(pcOut), .if_valid(ifValid)
  );

  if_stage_fetch #(.WORD_LEN(16), .PC_RESET(16'hFFFF)) dutWrap (
    .clk(clk), .rst(rst2), .hazard_detected_in(hazard2), .br_taken(brTaken2),
    .br_addr(brAddr2), .imem_req(imemReq2), .imem_addr(imemAddr2), .imem_ack(imemAck2),
    .imem_rdata(imemRdata2), .instruction(instr2), .pc_out(pcOut2), .if_valid(ifValid2)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic hz, logic br, logic [15:0] ba, logic ack,
                              logic [15:0] rd, logic [15:0] ei, logic [15:0] ep,
                              logic ev, logic er, logic [15:0] ea);
    vec_t v;
    v.name = n; v.hz = hz; v.br = br; v.ba = ba; v.ack = ack; v.rd = rd;
    v.eInstr = ei; v.ePc = ep; v.eValid = ev; v.eReq = er; v.eAddr = ea;
    return v;
  endfunction

  // Address is only compared while a request is expected to be pending.
  task automatic checkOutput(string n, logic [15:0] aI, logic [15:0] aP, logic aV,
                             logic aR, logic [15:0] aA, logic [15:0] eI, logic [15:0] eP,
                             logic eV, logic eR, logic [15:0] eA);
    logic bad;
    bad = (aI !== eI) || (aP !== eP) || (aV !== eV) || (aR !== eR) || (eR && (aA !== eA));
    nVec++;
    if (bad) begin
      nMis++;
      $display("[TB] FAIL %s: got instr=%h pc_out=%h valid=%b req=%b addr=%h, want instr=%h pc_out=%h valid=%b req=%b addr=%h",
               n, aI, aP, aV, aR, aA, eI, eP, eV, eR, eA);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    hazard    = v.hz;
    brTaken   = v.br;
    brAddr    = v.ba;
    imemAck   = v.ack;
    imemRdata = v.rd;
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    hazard = 1'b0; brTaken = 1'b0; brAddr = 16'h0000;
    imemAck = 1'b0; imemRdata = 16'h0000;
    imemAck2 = 1'b0; imemRdata2 = 16'h0000;

    //            name         hz br  ba       ack rd        instr    pc_out   v  req addr
    vecs.push_back(mk("idle2req", 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0000));
    vecs.push_back(mk("stream0",  0, 0, 16'h0000, 1, 16'hA000, 16'hA000, 16'h0001, 1, 1, 16'h0001));
    vecs.push_back(mk("stream1",  0, 0, 16'h0000, 1, 16'hA001, 16'hA001, 16'h0002, 1, 1, 16'h0002));
    vecs.push_back(mk("stream2",  0, 0, 16'h0000, 1, 16'hA002, 16'hA002, 16'h0003, 1, 1, 16'h0003));
    vecs.push_back(mk("stream3",  0, 0, 16'h0000, 1, 16'hA003, 16'hA003, 16'h0004, 1, 1, 16'h0004));
    vecs.push_back(mk("stream4",  0, 0, 16'h0000, 1, 16'hA004, 16'hA004, 16'h0005, 1, 1, 16'h0005));
    vecs.push_back(mk("frzWait",  1, 0, 16'h0000, 0, 16'h0000, 16'hA004, 16'h0005, 1, 1, 16'h0005));
    vecs.push_back(mk("frzAck",   1, 0, 16'h0000, 1, 16'hA005, 16'hA004, 16'h0005, 1, 0, 16'h0000));
    vecs.push_back(mk("frzHold1", 1, 0, 16'h0000, 0, 16'h0000, 16'hA004, 16'h0005, 1, 0, 16'h0000));
    vecs.push_back(mk("frzHold2", 1, 0, 16'h0000, 0, 16'h0000, 16'hA004, 16'h0005, 1, 0, 16'h0000));
    vecs.push_back(mk("skidOut",  0, 0, 16'h0000, 0, 16'h0000, 16'hA005, 16'h0006, 1, 1, 16'h0006));
    vecs.push_back(mk("bubble",   0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0006, 0, 1, 16'h0006));
    vecs.push_back(mk("fetch6",   0, 0, 16'h0000, 1, 16'hA006, 16'hA006, 16'h0007, 1, 1, 16'h0007));
    vecs.push_back(mk("fetch7",   0, 0, 16'h0000, 1, 16'hA007, 16'hA007, 16'h0008, 1, 1, 16'h0008));
    vecs.push_back(mk("wait8",    0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0008, 0, 1, 16'h0008));
    vecs.push_back(mk("brMid",    0, 1, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0008, 0, 1, 16'h0008));
    vecs.push_back(mk("staleWt",  0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0008, 0, 1, 16'h0008));
    vecs.push_back(mk("staleAck", 0, 0, 16'h0000, 1, 16'hA008, 16'h0000, 16'h0008, 0, 1, 16'h0040));
    vecs.push_back(mk("tgt40",    0, 0, 16'h0000, 1, 16'hA040, 16'hA040, 16'h0041, 1, 1, 16'h0041));
    vecs.push_back(mk("brAckHz",  1, 1, 16'h0100, 1, 16'hA041, 16'h0000, 16'h0041, 0, 1, 16'h0100));
    vecs.push_back(mk("tgt100",   0, 0, 16'h0000, 1, 16'hA100, 16'hA100, 16'h0101, 1, 1, 16'h0101));
    vecs.push_back(mk("brStale1", 0, 1, 16'h0200, 0, 16'h0000, 16'h0000, 16'h0101, 0, 1, 16'h0101));
    vecs.push_back(mk("brStale2", 0, 1, 16'h0300, 0, 16'h0000, 16'h0000, 16'h0101, 0, 1, 16'h0101));
    vecs.push_back(mk("staleAk2", 0, 0, 16'h0000, 1, 16'hA101, 16'h0000, 16'h0101, 0, 1, 16'h0300));
    vecs.push_back(mk("tgt300",   0, 0, 16'h0000, 1, 16'hA300, 16'hA300, 16'h0301, 1, 1, 16'h0301));
    vecs.push_back(mk("holdAgain",1, 0, 16'h0000, 1, 16'hA301, 16'hA300, 16'h0301, 1, 0, 16'h0000));
    vecs.push_back(mk("brHold",   1, 1, 16'h0500, 0, 16'h0000, 16'h0000, 16'h0301, 0, 1, 16'h0500));
    vecs.push_back(mk("tgt500",   0, 0, 16'h0000, 1, 16'hA500, 16'hA500, 16'h0501, 1, 1, 16'h0501));

    repeat (2) @(negedge clk);
    checkOutput("resetState", instr, pcOut, ifValid, imemReq, imemAddr,
                16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    if (imemAddr !== 16'h0000) begin
      nMis++;
      $display("[TB] FAIL resetAddr: got %h, want 0000", imemAddr);
    end
    nVec++;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(vecs[i].name, instr, pcOut, ifValid, imemReq, imemAddr,
                  vecs[i].eInstr, vecs[i].ePc, vecs[i].eValid, vecs[i].eReq, vecs[i].eAddr);
      @(negedge clk);
    end

    // Fetch of 0x501 is outstanding here; reset must clear outputs without a clock edge.
    hazard = 1'b0; brTaken = 1'b0; imemAck = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("asyncRst", instr, pcOut, ifValid, imemReq, imemAddr,
                16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    imemAck = 1'b1; imemRdata = 16'hDEAD;
    @(posedge clk);
    #1;
    checkOutput("lateAckIgn", instr, pcOut, ifValid, imemReq, imemAddr,
                16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    imemAck = 1'b1; imemRdata = 16'hA000;
    @(posedge clk);
    #1;
    checkOutput("restart0", instr, pcOut, ifValid, imemReq, imemAddr,
                16'hA000, 16'h0001, 1'b1, 1'b1, 16'h0001);
    @(negedge clk);
    imemAck = 1'b0;

    checkOutput("wrapReset", instr2, pcOut2, ifValid2, imemReq2, imemAddr2,
                16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    if (imemAddr2 !== 16'hFFFF) begin
      nMis++;
      $display("[TB] FAIL wrapRstAddr: got %h, want ffff", imemAddr2);
    end
    nVec++;
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wrapReq", instr2, pcOut2, ifValid2, imemReq2, imemAddr2,
                16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
    @(negedge clk);
    imemAck2 = 1'b1; imemRdata2 = 16'h5FFF;
    @(posedge clk);
    #1;
    checkOutput("wrapFetch", instr2, pcOut2, ifValid2, imemReq2, imemAddr2,
                16'h5FFF, 16'h0000, 1'b1, 1'b1, 16'h0000);
    @(negedge clk);
    imemAck2 = 1'b1; imemRdata2 = 16'hA000;
    @(posedge clk);
    #1;
    checkOutput("wrapNext", instr2, pcOut2, ifValid2, imemReq2, imemAddr2,
                16'hA000, 16'h0001, 1'b1, 1'b1, 16'h0001);
    @(negedge clk);
    imemAck2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
